multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM, with one Mealy term, that sequences the 16-bit accumulator multicycle datapath through fetch, decode, execute and writeback.
- Consumes Op, Func and Zero from the datapath.
- Drives every mux select, write enable and ALU control the datapath exposes.
- Sits beside the datapath inside the CPU top level.
- R0 is the accumulator. Instruction word: Op = Instr[15:12], register field Instr[11:9], Func = Instr[8:0].

Parameters:
STATE_W, 4, width of state register and dbg_state output (fixed encoding below; must be >= 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
Op  input  4  opcode from IR
Func  input  9  function field from IR
Zero  input  1  ALU zero flag (combinational, current cycle)
AdrSrc  output  1  0 = PC, 1 = Instr[11:0]
MemWrite  output  1  memory write enable
IRWrite  output  1  IR load
RegWrite  output  1  register file write
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A
ALUSrcB  output  2  00 = B, 01 = constant 1, 10 = ImmExt
ImmSrc  output  2  00 = sign-extend Instr[11:0], 01 = zero-extend Instr[11:0]
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT In2, 101 pass In2, 110 pass In1
A3Src  output  1  0 = R0, 1 = Instr[11:9]
PCWrite  output  1  PC load
PCSrc  output  2  00 = ALUResult, 01 = jump target, 10 = branch target
OldPCWrite  output  1  OldPC load
MDRWrite  output  1  MDR load
ResultSrc  output  1  0 = ALUOut, 1 = MDR
AWrite  output  1  A latch load
BWrite  output  1  B latch load
illegal  output  1  one-cycle pulse in DECODE when the opcode or Func is undefined
dbg_state  output  STATE_W  current state

Behaviour:
- Opcodes:
  - LOAD 0000: R0 <= Mem[Instr[11:0]]
  - STORE 0001: Mem[Instr[11:0]] <= R0
  - JUMP 0010: PC <= Instr[11:0]
  - BRZ 0100: if R0 == 0, PC <= {OldPC[11:9], Instr[8:0]}
  - TYPEC 1000
  - ADDI 1100, SUBI 1101 (ImmSrc 00)
  - ANDI 1110, ORI 1111 (ImmSrc 01)
  - All other opcodes are illegal.
- TYPEC Func is one-hot in Func[7:0], with Func[8] = 0:
  - bit0 MOVETO: Ri <= R0
  - bit1 MOVEFROM: R0 <= Ri
  - bit2 ADD, bit3 SUB, bit4 AND, bit5 OR: R0 <= R0 op Ri
  - bit6 NOT: R0 <= ~Ri
  - bit7 NOP
  - Zero bits set, more than one bit set, or Func[8] = 1: illegal.
- Any output not listed for a state is 0.
- State encoding and actions:
  - FETCH (0): AdrSrc=0, IRWrite, OldPCWrite, ALUSrcA=00, ALUSrcB=01, ADD, PCSrc=00, PCWrite -> DECODE.
  - DECODE (1): AWrite, BWrite. Next state:
    - LOAD -> MEMRD
    - STORE -> MEMWR
    - JUMP -> JMP
    - BRZ -> BRZ
    - TYPEC non-NOP -> EXEC
    - immediate ops -> EXECI
    - NOP or illegal -> FETCH, with illegal=1 for the illegal case.
  - MEMRD (2): AdrSrc=1, MDRWrite -> LDWB.
  - LDWB (3): RegWrite, A3Src=0, ResultSrc=1 -> FETCH.
  - MEMWR (4): AdrSrc=1, MemWrite -> FETCH. Write data is A, i.e. R0.
  - JMP (5): PCSrc=01, PCWrite -> FETCH.
  - BRZ (6): ALUSrcA=10, ALUControl=110, PCSrc=10, PCWrite=Zero (Mealy term) -> FETCH.
  - EXEC (7): ALUSrcA=10, ALUSrcB=00.
    - ALUControl per Func: MOVETO 110, MOVEFROM 101, ADD 000, SUB 001, AND 010, OR 011, NOT 100.
    - Next state: ALUWB.
  - EXECI (8): ALUSrcA=10, ALUSrcB=10, ImmSrc per opcode, ALUControl = 000/001/010/011 for ADDI/SUBI/ANDI/ORI -> ALUWB.
  - ALUWB (9): RegWrite, ResultSrc=0. A3Src=1 only when Op=TYPEC and Func bit0 is set, else 0. Next state: FETCH.
- ALUOut has no enable; it captures every cycle. ALUWB therefore must immediately follow EXEC/EXECI.
- The controller decodes Op/Func continuously from the IR. IR is stable from DECODE until the next FETCH.
- Latency in cycles, start of FETCH to next FETCH:
  - NOP/illegal: 2
  - STORE, JUMP, BRZ: 3
  - LOAD, TYPEC ALU, immediate: 4
- Reset:
  - reset=0 forces state to FETCH asynchronously.
  - While reset=0, every write enable (MemWrite, IRWrite, RegWrite, PCWrite, OldPCWrite, MDRWrite, AWrite, BWrite) and illegal are forced to 0.
  - First fetch occurs on the first rising edge after reset returns to 1.
  - Reset mid-instruction abandons the instruction with no partial write.
- Unused state encodings 10-15 -> FETCH on the next edge, all enables 0.

Test Plan:
- Reset held low 3 cycles, released: dbg_state=0 and all enables 0 during reset; first edge after release sees IRWrite=PCWrite=OldPCWrite=1, then dbg_state=1.
- Op=0000: states 0,1,2,3,0; MDRWrite=1 with AdrSrc=1 in state 2; RegWrite=1, ResultSrc=1, A3Src=0 in state 3.
- Op=1000, Func=9'h004 (ADD): EXEC shows ALUControl=000, ALUSrcA=10, ALUSrcB=00; ALUWB shows RegWrite=1, A3Src=0. Func=9'h001 (MOVETO): ALUControl=110, A3Src=1.
- Op=0100 with Zero=1 in BRZ -> PCWrite=1, PCSrc=10. Zero=0 -> PCWrite=0; returns to FETCH either way.
- Op=0011 (illegal) and Op=1000 with Func=9'h006: illegal=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite.
- Reset asserted during state 2 of a LOAD: state jumps to 0 immediately, no RegWrite occurs, normal fetch after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM for the 16-bit accumulator multicycle datapath.
// Sequences fetch, decode, execute and writeback. All outputs are Moore
// (state only) except PCWrite in BRZ, which follows the live Zero flag.
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         Op,
   input  logic [8:0]         Func,
   input  logic               Zero,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ImmSrc,
   output logic [2:0]         ALUControl,
   output logic               A3Src,
   output logic               PCWrite,
   output logic [1:0]         PCSrc,
   output logic               OldPCWrite,
   output logic               MDRWrite,
   output logic               ResultSrc,
   output logic               AWrite,
   output logic               BWrite,
   output logic               illegal,
   output logic [STATE_W-1:0] dbg_state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = STATE_W'(0),
      S_DECODE = STATE_W'(1),
      S_MEMRD  = STATE_W'(2),
      S_LDWB   = STATE_W'(3),
      S_MEMWR  = STATE_W'(4),
      S_JMP    = STATE_W'(5),
      S_BRZ    = STATE_W'(6),
      S_EXEC   = STATE_W'(7),
      S_EXECI  = STATE_W'(8),
      S_ALUWB  = STATE_W'(9)
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_func_ok;
   logic   w_typec;

   // TYPEC Func must be exactly one of the eight low bits with Func[8] clear.
   assign w_func_ok = !Func[8] && $onehot(Func[7:0]);
   assign w_typec   = (Op == 4'b1000);
   assign dbg_state = r_state;

   // State register; async active-low reset parks the FSM in FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Next-state and output decode; enables are suppressed while in reset.
   always_comb begin
      w_next     = S_FETCH;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      ALUControl = 3'b000;
      A3Src      = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      OldPCWrite = 1'b0;
      MDRWrite   = 1'b0;
      ResultSrc  = 1'b0;
      AWrite     = 1'b0;
      BWrite     = 1'b0;
      illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            IRWrite    = 1'b1;
            OldPCWrite = 1'b1;
            ALUSrcB    = 2'b01;
            PCWrite    = 1'b1;
            w_next     = S_DECODE;
         end
         S_DECODE: begin
            AWrite = 1'b1;
            BWrite = 1'b1;
            case (Op)
               4'b0000: w_next = S_MEMRD;
               4'b0001: w_next = S_MEMWR;
               4'b0010: w_next = S_JMP;
               4'b0100: w_next = S_BRZ;
               4'b1000: begin
                  if (!w_func_ok)   illegal = 1'b1;
                  else if (!Func[7]) w_next = S_EXEC;
               end
               4'b1100, 4'b1101, 4'b1110, 4'b1111: w_next = S_EXECI;
               default: illegal = 1'b1;
            endcase
         end
         S_MEMRD: begin
            AdrSrc   = 1'b1;
            MDRWrite = 1'b1;
            w_next   = S_LDWB;
         end
         S_LDWB: begin
            RegWrite  = 1'b1;
            ResultSrc = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_JMP: begin
            PCSrc   = 2'b01;
            PCWrite = 1'b1;
         end
         S_BRZ: begin
            ALUSrcA    = 2'b10;
            ALUControl = 3'b110;
            PCSrc      = 2'b10;
            PCWrite    = Zero;
         end
         S_EXEC: begin
            ALUSrcA = 2'b10;
            case (Func[7:0])
               8'h01:   ALUControl = 3'b110;
               8'h02:   ALUControl = 3'b101;
               8'h04:   ALUControl = 3'b000;
               8'h08:   ALUControl = 3'b001;
               8'h10:   ALUControl = 3'b010;
               8'h20:   ALUControl = 3'b011;
               8'h40:   ALUControl = 3'b100;
               default: ALUControl = 3'b000;
            endcase
            w_next = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b10;
            ImmSrc     = Op[1] ? 2'b01 : 2'b00;
            ALUControl = {1'b0, Op[1:0]};
            w_next     = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            A3Src    = w_typec && Func[0];
         end
         default: w_next = S_FETCH;
      endcase
      if (!reset) begin
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         PCWrite    = 1'b0;
         OldPCWrite = 1'b0;
         MDRWrite   = 1'b0;
         AWrite     = 1'b0;
         BWrite     = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each issued instruction expands
// into its expected per-cycle control words; a monitor pops and compares.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Op;
   logic [8:0] Func;
   logic       Zero;
   logic       AdrSrc, MemWrite, IRWrite, RegWrite, A3Src, PCWrite;
   logic       OldPCWrite, MDRWrite, ResultSrc, AWrite, BWrite, illegal;
   logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, PCSrc;
   logic [2:0] ALUControl;
   logic [3:0] dbg_state;

   typedef struct packed {
      logic [3:0] st;
      logic       adr, memw, irw, regw;
      logic [1:0] srca, srcb, imm;
      logic [2:0] aluc;
      logic       a3, pcw;
      logic [1:0] pcsrc;
      logic       oldpcw, mdrw, ressrc, aw, bw, ill;
   } rec_t;

   rec_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_cyc   = 0;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero),
      .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .A3Src(A3Src),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .OldPCWrite(OldPCWrite),
      .MDRWrite(MDRWrite), .ResultSrc(ResultSrc), .AWrite(AWrite),
      .BWrite(BWrite), .illegal(illegal), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic rec_t reset_rec();
      rec_t r = '0;
      r.srcb = 2'b01;
      return r;
   endfunction

   function automatic rec_t fetch_rec();
      rec_t r = reset_rec();
      r.irw = 1'b1; r.oldpcw = 1'b1; r.pcw = 1'b1;
      return r;
   endfunction

   // Expand one instruction into its cycle-by-cycle expected control words.
   task automatic issue(input logic [3:0] op, input logic [8:0] fn, input logic z);
      rec_t r;
      int   n = 0;
      bit   ok_fn = !fn[8] && ($countones(fn[7:0]) == 1);
      bit   ill = 1'b0;
      logic [2:0] alu_tbl [8] = '{3'b110, 3'b101, 3'b000, 3'b001,
                                  3'b010, 3'b011, 3'b100, 3'b000};
      Op = op; Func = fn; Zero = z;
      q.push_back(fetch_rec()); n++;
      if (op == 4'd8) ill = !ok_fn;
      else if (!(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd13, 4'd14, 4'd15})) ill = 1'b1;
      r = '0; r.st = 4'd1; r.aw = 1'b1; r.bw = 1'b1; r.ill = ill;
      q.push_back(r); n++;
      if (!ill) begin
         case (op)
            4'd0: begin
               r = '0; r.st = 4'd2; r.adr = 1'b1; r.mdrw = 1'b1; q.push_back(r); n++;
               r = '0; r.st = 4'd3; r.regw = 1'b1; r.ressrc = 1'b1; q.push_back(r); n++;
            end
            4'd1: begin
               r = '0; r.st = 4'd4; r.adr = 1'b1; r.memw = 1'b1; q.push_back(r); n++;
            end
            4'd2: begin
               r = '0; r.st = 4'd5; r.pcsrc = 2'b01; r.pcw = 1'b1; q.push_back(r); n++;
            end
            4'd4: begin
               r = '0; r.st = 4'd6; r.srca = 2'b10; r.aluc = 3'b110;
               r.pcsrc = 2'b10; r.pcw = z; q.push_back(r); n++;
            end
            4'd8: begin
               if (!fn[7]) begin
                  r = '0; r.st = 4'd7; r.srca = 2'b10;
                  for (int b = 0; b < 7; b++) if (fn[b]) r.aluc = alu_tbl[b];
                  q.push_back(r); n++;
                  r = '0; r.st = 4'd9; r.regw = 1'b1; r.a3 = fn[0]; q.push_back(r); n++;
               end
            end
            default: begin
               r = '0; r.st = 4'd8; r.srca = 2'b10; r.srcb = 2'b10;
               r.imm = (op >= 4'd14) ? 2'b01 : 2'b00;
               r.aluc = 3'(op - 4'd12);
               q.push_back(r); n++;
               r = '0; r.st = 4'd9; r.regw = 1'b1; q.push_back(r); n++;
            end
         endcase
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic check1(input string name, input logic [3:0] got, input logic [3:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   // Monitor: compare DUT control word against the scoreboard every cycle.
   initial begin
      rec_t exp_r, act;
      forever begin
         @(negedge clk);
         #1;
         n_cyc++;
         if (q.size() > 0) begin
            exp_r = q.pop_front();
            act = {dbg_state, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
                   ImmSrc, ALUControl, A3Src, PCWrite, PCSrc, OldPCWrite, MDRWrite,
                   ResultSrc, AWrite, BWrite, illegal};
            n_tests++;
            if (act !== exp_r) begin
               n_fail++;
               $display("FAIL cycle%0d op=%h func=%h: got %h, want %h",
                        n_cyc, Op, Func, act, exp_r);
            end
         end
      end
   end

   initial begin
      logic [8:0] fn;
      reset = 1'b0; Op = 4'd0; Func = 9'd0; Zero = 1'b0;
      // Reset held for three observed cycles.
      @(negedge clk);
      repeat (3) q.push_back(reset_rec());
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Directed cases.
      issue(4'b0000, 9'h000, 1'b0);
      issue(4'b1000, 9'h004, 1'b0);
      issue(4'b1000, 9'h001, 1'b1);
      issue(4'b0100, 9'h000, 1'b1);
      issue(4'b0100, 9'h000, 1'b0);
      issue(4'b0011, 9'h000, 1'b0);
      issue(4'b1000, 9'h006, 1'b0);
      issue(4'b1000, 9'h080, 1'b0);
      issue(4'b1000, 9'h104, 1'b0);
      issue(4'b1000, 9'h000, 1'b0);
      issue(4'b0001, 9'h000, 1'b0);
      issue(4'b0010, 9'h000, 1'b0);
      issue(4'b1100, 9'h000, 1'b0);
      issue(4'b1101, 9'h000, 1'b0);
      issue(4'b1110, 9'h000, 1'b0);
      issue(4'b1111, 9'h000, 1'b0);
      for (int b = 0; b < 7; b++) issue(4'b1000, 9'(1 << b), 1'b0);

      // Reset in MEMRD of a LOAD: abandon with no writeback.
      Op = 4'b0000; Func = 9'h000; Zero = 1'b0;
      q.push_back(fetch_rec());
      begin
         rec_t r;
         r = '0; r.st = 4'd1; r.aw = 1'b1; r.bw = 1'b1; q.push_back(r);
         r = '0; r.st = 4'd2; r.adr = 1'b1; r.mdrw = 1'b1; q.push_back(r);
      end
      repeat (2) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      check1("async_reset_state", dbg_state, 4'd0);
      check1("async_reset_regwrite", {3'b000, RegWrite}, 4'd0);
      q.push_back(reset_rec());
      repeat (2) @(negedge clk);
      reset = 1'b1;
      issue(4'b0000, 9'h000, 1'b1);

      // Randomized instruction stream.
      repeat (300) begin
         case ($urandom_range(0, 3))
            0:       fn = 9'($urandom);
            default: fn = 9'(1 << $urandom_range(0, 7));
         endcase
         issue(4'($urandom_range(0, 15)), fn, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      #2;
      check1("scoreboard_drained", 4'(q.size()), 4'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
